prbs31_test_ctrl: RTL
=====================

# prbs31_test_ctrl

Sequencer and self-synchronising checker for the PRBS31 link test. It drives the PRBS31 generator's seed-load and advance strobes and forwards the generator bit to the transmit pin. It locks onto the received stream, counts bit errors over a programmed burst, and reports busy, locked, done and error status to the top-level I/O.

## Interface
Parameters:
- BURST_W, 16, width of burst length and bit counter
- ERR_W, 8, width of saturating error counter
- SYNC_CYCLES, 31, received bits shifted in before comparison starts (≥31)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-high
- cmd_start  input  1  start a test (single-cycle pulse or level; edge not required)
- cmd_stop  input  1  abort/clear to IDLE
- burst_len  input  BURST_W  bits to compare in RUN; 0 = continuous; sampled on accepted start
- gen_bit  input  1  current output bit of PRBS31 generator
- rx_bit  input  1  received bit, one per clk
- gen_load  output  1  one-cycle strobe: generator reloads seed 31'd1
- gen_en  output  1  generator advances when high
- tx_bit  output  1  bit driven to the link
- busy  output  1  state not IDLE/DONE
- locked  output  1  state is RUN
- done  output  1  state is DONE
- err_cnt  output  ERR_W  errors counted in RUN
- err_sat  output  1  err_cnt reached all-ones

## Operation
- States: IDLE, SEED, SYNC, RUN, DONE. On reset: IDLE, all outputs 0, err_cnt=0, counters 0, rx_sh=0.
- IDLE: cmd_start → SEED; burst_len latched; err_cnt, err_sat and rx_sh cleared.
- SEED: one cycle; gen_load=1, gen_en=0 → SYNC.
- SYNC: gen_en=1; rx_bit shifts into 31-bit rx_sh (rx_sh[0] ← rx_bit, rx_sh[30:1] ← rx_sh[29:0]); no errors counted; after SYNC_CYCLES shifts → RUN.
- RUN: gen_en=1; expected = rx_sh[27]^rx_sh[30]; error when rx_bit ≠ expected; rx_bit still shifts in (self-synchronising). Bit counter increments per cycle; when it equals latched burst_len (nonzero) → DONE. burst_len=0 runs until cmd_stop.
- DONE: gen_en=0; err_cnt held; cmd_start → SEED (restart); cmd_stop → IDLE.
- cmd_stop in any state → IDLE next cycle; err_cnt held (not cleared) for readout.
- Simultaneous cmd_start and cmd_stop: stop wins. cmd_start while busy: ignored.
- err_cnt saturates at 2^ERR_W−1; err_sat set on saturation, sticky until next accepted start or reset.
- tx_bit = gen_bit, registered-free passthrough (see Configuration).
- Reset asserted mid-test: immediate return to IDLE state values; no partial result retained.

## Timing
- start sampled edge N → SEED during N+1 (gen_load high) → SYNC from N+2.
- locked rises exactly SYNC_CYCLES cycles after SYNC entry.
- Error detected in cycle k is visible on err_cnt after edge k+1.
- done rises the cycle after the burst_len-th RUN comparison; exactly burst_len comparisons made.
- A single flipped bit in a clean stream yields exactly 3 counted errors (direct, then at taps 27 and 30).

## Configuration
- PRBS_ERR_INJECT_EN defined: extra input inject (1 bit); tx_bit = gen_bit ^ inject, gated to RUN state only. Otherwise inject is ignored.
- Undefined: no inject port; tx_bit = gen_bit.

## Structure
- Shared package prbs_pkg: state enum (IDLE, SEED, SYNC, RUN, DONE), PRBS31 seed constant 31'd1, tap constants 27 and 30.
- One sub-module: prbs31_chk (rx_sh register, expected-bit compare, err_o), instantiated by the controller FSM; counters and saturation stay in the controller.

## Test plan
- Loopback rx_bit=tx_bit, burst_len=1000 → locked after 31 SYNC cycles, done after 1000 comparisons, err_cnt=0.
- Loopback with one bit flipped on rx mid-RUN → err_cnt=3.
- rx_bit stuck at 1, burst_len=400, ERR_W=8 → err_cnt=255, err_sat=1, done=1.
- burst_len=0, run 5000 cycles, then cmd_stop → still locked before stop, IDLE after 1 cycle, err_cnt held.
- cmd_start and cmd_stop in same cycle from IDLE → stays IDLE. rst_n pulse during RUN → all outputs 0 immediately.
- With PRBS_ERR_INJECT_EN, loopback, inject pulses on 2 RUN cycles (≥31 apart) → err_cnt=6.

Source files
------------

// File: rtl/prbs31_test_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_pkg: shared state encoding and PRBS31 constants for the link test.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package prbs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEED = 3'd1,
    ST_SYNC = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [30:0] c_prbs31_seed = 31'd1;
  localparam int          c_tap_a       = 27;
  localparam int          c_tap_b       = 30;

  // x^31 + x^28 + 1: the next bit equals the bits 28 and 31 positions back.
  function automatic logic prbs31_expect(input logic [30:0] sh);
    return sh[c_tap_a] ^ sh[c_tap_b];
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs31_test_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs31_test_ctrl_if: command, generator and status bundle of the test.   |
// | Optional port inject exists when PRBS_ERR_INJECT_EN is defined.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface prbs31_test_ctrl_if #(
  parameter int BURST_W = 16,
  parameter int ERR_W   = 8
);
  logic               cmd_start;
  logic               cmd_stop;
  logic [BURST_W-1:0] burst_len;
  logic               gen_bit;
  logic               rx_bit;
  logic               gen_load;
  logic               gen_en;
  logic               tx_bit;
  logic               busy;
  logic               locked;
  logic               done;
  logic [ERR_W-1:0]   err_cnt;
  logic               err_sat;
`ifdef PRBS_ERR_INJECT_EN
  logic               inject;
`endif

  modport slave (
    input  cmd_start, cmd_stop, burst_len, gen_bit, rx_bit,
`ifdef PRBS_ERR_INJECT_EN
    input  inject,
`endif
    output gen_load, gen_en, tx_bit, busy, locked, done, err_cnt, err_sat
  );

  modport master (
    output cmd_start, cmd_stop, burst_len, gen_bit, rx_bit,
`ifdef PRBS_ERR_INJECT_EN
    output inject,
`endif
    input  gen_load, gen_en, tx_bit, busy, locked, done, err_cnt, err_sat
  );
endinterface
`default_nettype wire

// File: rtl/prbs31_chk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs31_chk: self-synchronising PRBS31 receive shift register and compare.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prbs31_chk
  import prbs_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr,
  input  wire logic shift_en,
  input  wire logic rx_bit,
  output logic      err_o
);

  logic [30:0] r_rx_sh;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rx_sh <= '0;
    end else if (clr) begin
      r_rx_sh <= '0;
    end else if (shift_en) begin
      r_rx_sh <= {r_rx_sh[29:0], rx_bit};
    end
  end

  // Expected bit comes from received history, so lock needs no seed alignment.
  assign err_o = rx_bit ^ prbs31_expect(r_rx_sh);

endmodule
`default_nettype wire

// File: rtl/prbs31_test_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs31_test_ctrl: PRBS31 link test sequencer, error counter and status.  |
// | Define PRBS_ERR_INJECT_EN to add the inject input (tx flip in RUN).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prbs31_test_ctrl
  import prbs_pkg::*;
#(
  parameter int BURST_W     = 16,
  parameter int ERR_W       = 8,
  parameter int SYNC_CYCLES = 31
) (
  input wire logic          clk,
  input wire logic          rst_n,
  prbs31_test_ctrl_if.slave bus
);

  localparam int SYNC_W = $clog2(SYNC_CYCLES + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BURST_W-1:0] r_burst_len;
  logic [BURST_W-1:0] r_bit_cnt;
  logic [BURST_W-1:0] w_bit_nxt;
  logic [SYNC_W-1:0]  r_sync_cnt;
  logic [ERR_W-1:0]   r_err_cnt;
  logic               r_err_sat;
  logic               w_start_acc;
  logic               w_chk_err;
  logic               w_shift_en;
  logic               w_sync_last;
  logic               w_burst_last;

  assign w_start_acc  = bus.cmd_start && !bus.cmd_stop &&
                        (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_bit_nxt    = r_bit_cnt + BURST_W'(1);
  assign w_sync_last  = (r_sync_cnt == SYNC_W'(SYNC_CYCLES - 1));
  assign w_burst_last = (r_burst_len != '0) && (w_bit_nxt == r_burst_len);
  assign w_shift_en   = (r_state == ST_SYNC) || (r_state == ST_RUN);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.cmd_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.cmd_start) w_state_nxt = ST_SEED;
        ST_SEED: w_state_nxt = ST_SYNC;
        ST_SYNC: if (w_sync_last) w_state_nxt = ST_RUN;
        ST_RUN:  if (w_burst_last) w_state_nxt = ST_DONE;
        ST_DONE: if (bus.cmd_start) w_state_nxt = ST_SEED;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_burst_len <= '0;
      r_bit_cnt   <= '0;
      r_sync_cnt  <= '0;
      r_err_cnt   <= '0;
      r_err_sat   <= 1'b0;
    end else if (w_start_acc) begin
      r_burst_len <= bus.burst_len;
      r_bit_cnt   <= '0;
      r_sync_cnt  <= '0;
      r_err_cnt   <= '0;
      r_err_sat   <= 1'b0;
    end else begin
      if (r_state == ST_SYNC) begin
        r_sync_cnt <= r_sync_cnt + SYNC_W'(1);
      end
      if (r_state == ST_RUN) begin
        r_bit_cnt <= w_bit_nxt;
      end
      // Saturate at all-ones; the flag rises on the same edge as the count.
      if (r_state == ST_RUN && w_chk_err && r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
        if (r_err_cnt == {{(ERR_W-1){1'b1}}, 1'b0}) begin
          r_err_sat <= 1'b1;
        end
      end
    end
  end

  prbs31_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_start_acc),
    .shift_en(w_shift_en),
    .rx_bit  (bus.rx_bit),
    .err_o   (w_chk_err)
  );

  assign bus.gen_load = (r_state == ST_SEED);
  assign bus.gen_en   = w_shift_en;
  assign bus.busy     = (r_state == ST_SEED) || w_shift_en;
  assign bus.locked   = (r_state == ST_RUN);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.err_cnt  = r_err_cnt;
  assign bus.err_sat  = r_err_sat;

`ifdef PRBS_ERR_INJECT_EN
  assign bus.tx_bit = bus.gen_bit ^ (bus.inject && (r_state == ST_RUN));
`else
  assign bus.tx_bit = bus.gen_bit;
`endif

endmodule
`default_nettype wire
